// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared defaults and run-state type for the counter controller
package counter_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_LIMIT = 9;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/counter_ctrl_count_datapath.sv
// count_datapath: count register with synchronous clear/enable and terminal compare
module count_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);
  // Count register; clear takes precedence over increment
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + WIDTH'(1);
  assign at_limit = count >= limit;
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: run/pause/stop sequencing, limit config and wrap/done pulses
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEFAULT_LIMIT = DEF_LIMIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_cfg_valid,
  output logic             io_cfg_ready,
  input  logic [WIDTH-1:0] io_cfg_limit,
  input  logic             io_cfg_oneshot,
  input  logic             io_start,
  input  logic             io_stop,
  input  logic             io_pause,
  output logic [WIDTH-1:0] io_count,
  output logic             io_busy,
  output logic             io_wrap,
  output logic             io_done
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] limit;
  logic oneshot, clear, enable, at_limit, wrap_nxt, done_nxt;
  assign io_cfg_ready = (state == IDLE) || (state == DONE);
  assign io_busy = !io_cfg_ready;
  count_datapath #(.WIDTH(WIDTH)) u_dp (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable),
    .limit(limit), .count(io_count), .at_limit(at_limit)
  );
  // Run-state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // Next state and datapath controls; a paused state releasing pause counts like RUN
  always_comb begin
    state_nxt = state;
    clear = 1'b0;
    enable = 1'b0;
    wrap_nxt = 1'b0;
    done_nxt = 1'b0;
    if (io_stop) begin
      state_nxt = IDLE;
      clear = 1'b1;
    end else if (io_cfg_ready) begin
      if (io_start) begin
        state_nxt = RUN;
        clear = 1'b1;
      end
    end else if (io_pause) state_nxt = PAUSE;
    else if (at_limit) begin
      clear = 1'b1;
      wrap_nxt = 1'b1;
      done_nxt = oneshot;
      state_nxt = oneshot ? DONE : RUN;
    end else begin
      enable = 1'b1;
      state_nxt = RUN;
    end
  end
  // Terminal count and mode, writable only while not busy
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      limit <= WIDTH'(DEFAULT_LIMIT);
      oneshot <= 1'b0;
    end else if (io_cfg_valid && io_cfg_ready) begin
      limit <= io_cfg_limit;
      oneshot <= io_cfg_oneshot;
    end
  // Registered event pulses
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      io_wrap <= 1'b0;
      io_done <= 1'b0;
    end else begin
      io_wrap <= wrap_nxt;
      io_done <= done_nxt;
    end
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed checks of counter_ctrl against a behavioural model
module tb_counter_ctrl;
  localparam int W = 8;
  logic clock = 0, reset = 1;
  logic io_cfg_valid = 0, io_cfg_oneshot = 0, io_start = 0, io_stop = 0, io_pause = 0;
  logic [W-1:0] io_cfg_limit = '0;
  logic io_cfg_ready, io_busy, io_wrap, io_done;
  logic [W-1:0] io_count;
  int total = 0, passed = 0;
  bit m_active, m_oneshot, m_wrap, m_done;
  int m_count, m_limit;

  always #5 clock = ~clock;

  counter_ctrl dut (
    .clock(clock), .reset(reset), .io_cfg_valid(io_cfg_valid), .io_cfg_ready(io_cfg_ready),
    .io_cfg_limit(io_cfg_limit), .io_cfg_oneshot(io_cfg_oneshot), .io_start(io_start),
    .io_stop(io_stop), .io_pause(io_pause), .io_count(io_count), .io_busy(io_busy),
    .io_wrap(io_wrap), .io_done(io_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_active = 0; m_oneshot = 0; m_wrap = 0; m_done = 0; m_count = 0; m_limit = 9;
  endfunction

  function automatic void model_step();
    bit busy = m_active;
    m_wrap = 0;
    m_done = 0;
    if (io_cfg_valid && !busy) begin
      m_limit = int'(io_cfg_limit);
      m_oneshot = io_cfg_oneshot;
    end
    if (io_stop) begin
      m_active = 0;
      m_count = 0;
    end else if (!busy) begin
      if (io_start) begin
        m_active = 1;
        m_count = 0;
      end
    end else if (!io_pause) begin
      if (m_count >= m_limit) begin
        m_count = 0;
        m_wrap = 1;
        if (m_oneshot) begin
          m_active = 0;
          m_done = 1;
        end
      end else m_count = (m_count + 1) % 256;
    end
  endfunction

  task automatic compare();
    chk("model_count", io_count, m_count);
    chk("model_busy", io_busy, m_active);
    chk("model_ready", io_cfg_ready, !m_active);
    chk("model_wrap", io_wrap, m_wrap);
    chk("model_done", io_done, m_done);
  endtask

  task automatic cyc();
    @(posedge clock);
    if (reset) model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic cfg_start(input logic [W-1:0] lim, input logic os);
    io_cfg_valid = 1; io_cfg_limit = lim; io_cfg_oneshot = os; io_start = 1;
    cyc();
    io_cfg_valid = 0; io_start = 0;
  endtask

  initial begin
    int pexp[4] = '{3, 4, 5, 0};
    model_reset();
    #1 reset = 0;
    #2;
    chk("rst_count", io_count, 0);
    chk("rst_busy", io_busy, 0);
    chk("rst_ready", io_cfg_ready, 1);
    chk("rst_wrap", io_wrap, 0);
    chk("rst_done", io_done, 0);
    @(negedge clock);
    reset = 1;
    io_start = 1;
    cyc();
    io_start = 0;
    chk("start_count", io_count, 0);
    for (int i = 1; i <= 21; i++) begin
      cyc();
      chk("def_count", io_count, i % 10);
      chk("def_wrap", io_wrap, (i % 10) == 0);
    end
    chk("def_busy", io_busy, 1);
    cycn(8);
    chk("pre_stop_count", io_count, 9);
    io_stop = 1; io_start = 1;
    cyc();
    io_stop = 0; io_start = 0;
    chk("stop_count", io_count, 0);
    chk("stop_busy", io_busy, 0);
    chk("stop_wrap", io_wrap, 0);
    chk("stop_done", io_done, 0);
    io_cfg_valid = 1; io_cfg_limit = 3; io_cfg_oneshot = 1;
    cyc();
    io_cfg_valid = 0;
    io_start = 1;
    cyc();
    io_start = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("os_count", io_count, i % 4);
      chk("os_wrap", io_wrap, i == 4);
    end
    chk("os_done", io_done, 1);
    chk("os_busy", io_busy, 0);
    chk("os_ready", io_cfg_ready, 1);
    cyc();
    chk("os_wrap_clr", io_wrap, 0);
    chk("os_done_clr", io_done, 0);
    cfg_start(5, 0);
    chk("p_start", io_count, 0);
    cycn(2);
    chk("p_pre", io_count, 2);
    io_pause = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("p_hold", io_count, 2);
      chk("p_busy", io_busy, 1);
    end
    io_pause = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("p_resume", io_count, pexp[i]);
      chk("p_wrap", io_wrap, i == 3);
    end
    io_stop = 1;
    cyc();
    io_stop = 0;
    cfg_start(9, 0);
    cycn(4);
    chk("rc_pre", io_count, 4);
    io_cfg_valid = 1; io_cfg_limit = 1;
    chk("rc_ready", io_cfg_ready, 0);
    cyc();
    io_cfg_valid = 0;
    chk("rc_count5", io_count, 5);
    for (int i = 6; i <= 10; i++) begin
      cyc();
      chk("rc_count", io_count, i % 10);
      chk("rc_wrap", io_wrap, i == 10);
    end
    cycn(6);
    chk("ar_pre", io_count, 6);
    #2 reset = 0;
    #1;
    chk("ar_count", io_count, 0);
    chk("ar_busy", io_busy, 0);
    chk("ar_ready", io_cfg_ready, 1);
    model_reset();
    @(negedge clock);
    reset = 1;
    io_start = 1;
    cyc();
    io_start = 0;
    cycn(9);
    chk("ar_lim9", io_count, 9);
    cyc();
    chk("ar_wrap", io_wrap, 1);
    cycn(2);
    io_start = 1;
    cyc();
    io_start = 0;
    chk("run_start_ign", io_count, 3);
    io_stop = 1;
    cyc();
    io_stop = 0;
    cfg_start(0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("l0_count", io_count, 0);
      chk("l0_wrap", io_wrap, 1);
    end
    io_stop = 1;
    cyc();
    io_stop = 0;
    cfg_start(255, 1);
    cycn(255);
    chk("full_top", io_count, 255);
    cyc();
    chk("full_count", io_count, 0);
    chk("full_wrap", io_wrap, 1);
    chk("full_done", io_done, 1);
    chk("full_busy", io_busy, 0);
    cyc();
    chk("full_done_clr", io_done, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Run controller and configuration front-end for the modulo counter datapath (+1 incrementer feeding a count register).
- Sequences the count with start, stop and pause, and holds a programmable terminal count (limit).
- Supports periodic (free-wrapping) and one-shot modes.
- Reports wrap and done events as single-cycle pulses to downstream logic.

Parameters:
- WIDTH, 8: count and limit width in bits.
- DEFAULT_LIMIT, 9: limit value loaded at reset. Must be < 2^WIDTH.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_cfg_valid  in  1  configuration request.
- io_cfg_ready  out  1  config accepted this cycle when valid && ready.
- io_cfg_limit  in  WIDTH  new terminal count.
- io_cfg_oneshot  in  1  1 = stop after first wrap; 0 = periodic.
- io_start  in  1  start request, sampled each cycle.
- io_stop  in  1  abort request, sampled each cycle.
- io_pause  in  1  level input; count holds while high.
- io_count  out  WIDTH  current count (registered).
- io_busy  out  1  high in RUN and PAUSE.
- io_wrap  out  1  one-cycle pulse, count wrapped limit -> 0.
- io_done  out  1  one-cycle pulse, one-shot run finished.

Behaviour:
- States: IDLE, RUN, PAUSE, DONE.
- Reset (reset low, async assert; release is synchronised by the system):
  - state = IDLE, io_count = 0, limit = DEFAULT_LIMIT, oneshot = 0.
  - io_wrap = 0, io_done = 0, io_busy = 0, io_cfg_ready = 1.
- io_cfg_ready = 1 in IDLE and DONE, 0 in RUN and PAUSE (combinational from state).
  - Accepted config updates the limit and oneshot registers at the same edge.
- Priority per cycle: stop > config > start > pause.
- Any state with io_stop = 1 -> IDLE and count := 0 next edge.
  - No wrap or done pulse is generated, even if count == limit.
- IDLE / DONE:
  - io_start = 1 -> RUN, count := 0.
  - A config accepted in the same cycle as start governs that run.
  - Otherwise hold state and count.
- RUN:
  - io_pause = 1 -> PAUSE, count holds.
  - Else if count >= limit: count := 0 and io_wrap = 1 in the following cycle.
    - If oneshot: -> DONE and io_done = 1 in that same cycle as io_wrap.
    - Else stay in RUN.
  - Else count := count + 1.
  - io_start in RUN is ignored; the count does not restart.
- PAUSE:
  - io_pause = 0 -> RUN. Counting resumes on the next edge.
  - Count is frozen for the whole pause.
- Arithmetic:
  - Increment is WIDTH bits, modulo 2^WIDTH.
  - The >= compare guards against count > limit.
  - limit = 0 means count stays 0 and wraps every RUN cycle.
  - limit = 2^WIDTH - 1 gives a full-range counter.
- Latency:
  - Start at edge k gives io_count = 0 after edge k and io_count = n after edge k+n.
  - Periodic wrap period is limit + 1 cycles.
- io_wrap and io_done are registered, never high for more than one consecutive cycle (except limit = 0 periodic, where io_wrap stays high).

Decomposition:
- Package counter_ctrl_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE), 2-bit encoding.
  - WIDTH default, DEFAULT_LIMIT default.
- Sub-module count_datapath holds the incrementer, count register, synchronous clear/enable and the limit compare.
  - Inputs: clear, enable, limit.
  - Outputs: count, at_limit.
- counter_ctrl holds the FSM, config registers and pulse generation.

Test Plan:
- Reset, then start=1 for one cycle, defaults -> count sequence 0,1,...,9,0,1 with io_wrap high only in the cycles count=0 after 9, every 10 cycles; io_busy=1.
- Config limit=3, oneshot=1 in IDLE, then start -> count 0,1,2,3,0; io_wrap and io_done both pulse once; state DONE; io_busy=0; io_cfg_ready=1.
- Periodic limit=5, pause high 4 cycles at count=2 -> count holds 2 for 4 cycles, then 3,4,5,0; wrap timing shifted by exactly 4 cycles.
- In RUN at count=4, assert cfg_valid with limit=1 -> io_cfg_ready=0, limit unchanged, count continues 5..9,0.
- Stop asserted at count=9 with start also high -> IDLE, count=0, no io_wrap/io_done pulse.
- Assert reset (low) asynchronously mid-run at count=6, between clock edges -> io_count=0 and io_busy=0 immediately; limit returns to 9.
